// File: rtl/intr_trap_ctrl_pkg.sv
// Shared definitions for the trap-entry/return controller: address width,
// default handler vector and the controller state encoding.
package intr_trap_ctrl_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_T_FLUSH = 3'd1;
  localparam logic [2:0] ST_T_REDIR = 3'd2;
  localparam logic [2:0] ST_R_FLUSH = 3'd3;
  localparam logic [2:0] ST_R_REDIR = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    T_FLUSH = ST_T_FLUSH,
    T_REDIR = ST_T_REDIR,
    R_FLUSH = ST_R_FLUSH,
    R_REDIR = ST_R_REDIR
  } trap_state_e;

endpackage

// File: rtl/intr_trap_ctrl.sv
// Trap-entry/return controller. Takes an interrupt on a valid D-stage
// instruction, saves its PC, flushes the pipe and redirects fetch to the
// handler; on mret restores the enable state and redirects back to epc.
module intr_trap_ctrl
  import intr_trap_ctrl_pkg::*;
#(
  parameter int               XLEN     = intr_trap_ctrl_pkg::XLEN,
  parameter logic [XLEN-1:0]  TRAP_VEC = intr_trap_ctrl_pkg::TRAP_VEC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            intr_pulse,
  input  logic            ifu_exu_vld_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic            mret_vld,
  input  logic            csr_mie_wr,
  input  logic            csr_mie_wdata,
  input  logic            redirect_rdy,
  output logic            trap_flush,
  output logic            redirect_vld,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] epc,
  output logic            mie,
  output logic            mpie,
  output logic            in_handler
);

  trap_state_e     r_state;
  trap_state_e     w_state_nxt;
  logic            w_flush;
  logic            w_redir;
  logic            w_ret;
  logic            w_take;
  logic            r_mie;
  logic            r_mpie;
  logic            r_pend;
  logic            r_in_handler;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] r_redirect_pc;

  // A return has priority over a trap that becomes eligible in the same cycle;
  // an mret outside the handler is ignored and does not block a trap.
  assign w_ret  = (r_state == IDLE) & mret_vld & r_in_handler;
  assign w_take = (r_state == IDLE) & r_mie & ifu_exu_vld_d &
                  (intr_pulse | r_pend) & ~w_ret;

  // State register, aborted to IDLE by reset at any point of a sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and the flush/redirect strobes derived from the state.
  always_comb begin
    w_state_nxt = r_state;
    w_flush     = 1'b0;
    w_redir     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ret)       w_state_nxt = R_FLUSH;
        else if (w_take) w_state_nxt = T_FLUSH;
      end
      T_FLUSH: begin
        w_flush     = 1'b1;
        w_state_nxt = T_REDIR;
      end
      T_REDIR: begin
        w_redir = 1'b1;
        if (redirect_rdy) w_state_nxt = IDLE;
      end
      R_FLUSH: begin
        w_flush     = 1'b1;
        w_state_nxt = R_REDIR;
      end
      R_REDIR: begin
        w_redir = 1'b1;
        if (redirect_rdy) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Interrupt-enable stack and pending latch; trap entry and return override
  // any CSR write in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mie  <= 1'b0;
      r_mpie <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      if (w_take) begin
        r_mpie <= r_mie;
        r_mie  <= 1'b0;
      end else if (w_ret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end else if (csr_mie_wr) begin
        r_mie  <= csr_mie_wdata;
      end
      if (w_take)          r_pend <= 1'b0;
      else if (intr_pulse) r_pend <= 1'b1;
    end
  end

  // Handler-residency flag: set on trap entry, cleared when the return
  // redirect is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_in_handler <= 1'b0;
    else if (w_take)                              r_in_handler <= 1'b1;
    else if ((r_state == R_REDIR) & redirect_rdy) r_in_handler <= 1'b0;
  end

  // Saved PC changes only on trap entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_epc <= '0;
    else if (w_take) r_epc <= pc_d;
  end

  // Redirect target is loaded during the flush cycle so it is already stable
  // when redirect_vld rises and stays put under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_redirect_pc <= '0;
    else if (r_state == T_FLUSH)   r_redirect_pc <= TRAP_VEC;
    else if (r_state == R_FLUSH)   r_redirect_pc <= r_epc;
  end

  assign trap_flush   = w_flush;
  assign redirect_vld = w_redir;
  assign redirect_pc  = r_redirect_pc;
  assign epc          = r_epc;
  assign mie          = r_mie;
  assign mpie         = r_mpie;
  assign in_handler   = r_in_handler;

endmodule

// File: tb/tb_intr_trap_ctrl.sv
// Bench for intr_trap_ctrl: directed scenarios followed by random traffic,
// all compared each cycle against a behavioural model of trap/return rules.
module tb_intr_trap_ctrl;

  localparam logic [31:0] VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        intr_pulse, ifu_exu_vld_d, mret_vld, csr_mie_wr, csr_mie_wdata, redirect_rdy;
  logic [31:0] pc_d;
  logic        trap_flush, redirect_vld, mie, mpie, in_handler;
  logic [31:0] redirect_pc, epc;

  int tests = 0;
  int fails = 0;

  // model state: enable stack, pending, handler flag, and the outstanding
  // flush/redirect work (flush this cycle, redirect active, target, is-return)
  bit          m_mie, m_mpie, m_pend, m_inh, m_flush, m_redir, m_ret;
  logic [31:0] m_epc, m_tgt;

  intr_trap_ctrl dut (
    .clk(clk), .rst_n(rst_n), .intr_pulse(intr_pulse), .ifu_exu_vld_d(ifu_exu_vld_d),
    .pc_d(pc_d), .mret_vld(mret_vld), .csr_mie_wr(csr_mie_wr), .csr_mie_wdata(csr_mie_wdata),
    .redirect_rdy(redirect_rdy), .trap_flush(trap_flush), .redirect_vld(redirect_vld),
    .redirect_pc(redirect_pc), .epc(epc), .mie(mie), .mpie(mpie), .in_handler(in_handler)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_pend = 0; m_inh = 0;
    m_flush = 0; m_redir = 0; m_ret = 0; m_epc = '0; m_tgt = '0;
  endtask

  task automatic check_model();
    chk("trap_flush", {31'd0, trap_flush}, {31'd0, m_flush});
    chk("redirect_vld", {31'd0, redirect_vld}, {31'd0, m_redir});
    if (m_redir) chk("redirect_pc", redirect_pc, m_tgt);
    chk("epc", epc, m_epc);
    chk("mie", {31'd0, mie}, {31'd0, m_mie});
    chk("mpie", {31'd0, mpie}, {31'd0, m_mpie});
    chk("in_handler", {31'd0, in_handler}, {31'd0, m_inh});
    if (trap_flush && redirect_vld) chk("flush_and_redir", 32'd1, 32'd0);
  endtask

  // One clock: drive inputs, predict the post-edge state, clock, then compare.
  task automatic step(input bit p, input bit v, input logic [31:0] pc, input bit mr,
                      input bit cw, input bit cd, input bit rdy);
    bit idle, ret, take;
    bit n_mie, n_mpie, n_pend, n_inh, n_flush, n_redir, n_ret;
    logic [31:0] n_epc, n_tgt;
    intr_pulse = p; ifu_exu_vld_d = v; pc_d = pc; mret_vld = mr;
    csr_mie_wr = cw; csr_mie_wdata = cd; redirect_rdy = rdy;
    idle = !m_flush && !m_redir;
    ret  = idle && mr && m_inh;
    take = idle && !ret && m_mie && v && (p || m_pend);
    n_mie = m_mie; n_mpie = m_mpie; n_pend = m_pend; n_inh = m_inh;
    n_flush = m_flush; n_redir = m_redir; n_ret = m_ret; n_epc = m_epc; n_tgt = m_tgt;
    if (m_flush) begin n_flush = 0; n_redir = 1; end
    if (m_redir && rdy) begin n_redir = 0; if (m_ret) n_inh = 0; end
    if (take) begin
      n_epc = pc; n_mpie = m_mie; n_mie = 0; n_pend = 0; n_inh = 1;
      n_flush = 1; n_tgt = VEC; n_ret = 0;
    end else if (ret) begin
      n_mie = m_mpie; n_mpie = 1; n_flush = 1; n_tgt = m_epc; n_ret = 1;
    end else if (cw) begin
      n_mie = cd;
    end
    if (p && !take) n_pend = 1;
    @(posedge clk);
    m_mie = n_mie; m_mpie = n_mpie; m_pend = n_pend; m_inh = n_inh;
    m_flush = n_flush; m_redir = n_redir; m_ret = n_ret; m_epc = n_epc; m_tgt = n_tgt;
    @(negedge clk);
    check_model();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_flush"}, {31'd0, trap_flush}, 32'd0);
    chk({tag, "_vld"}, {31'd0, redirect_vld}, 32'd0);
    chk({tag, "_rpc"}, redirect_pc, 32'd0);
    chk({tag, "_epc"}, epc, 32'd0);
    chk({tag, "_mie"}, {31'd0, mie}, 32'd0);
    chk({tag, "_mpie"}, {31'd0, mpie}, 32'd0);
    chk({tag, "_inh"}, {31'd0, in_handler}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    intr_pulse = 0; ifu_exu_vld_d = 0; pc_d = '0; mret_vld = 0;
    csr_mie_wr = 0; csr_mie_wdata = 0; redirect_rdy = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // trap entry with pc 0x200, then 3 cycles of backpressure
    step(0, 0, 0, 0, 1, 1, 0);
    step(1, 1, 32'h200, 0, 0, 0, 0);
    chk("t1_epc", epc, 32'h200);
    chk("t1_mie", {31'd0, mie}, 32'd0);
    chk("t1_mpie", {31'd0, mpie}, 32'd1);
    chk("t1_flush", {31'd0, trap_flush}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t1_vld", {31'd0, redirect_vld}, 32'd1);
    chk("t1_rpc", redirect_pc, 32'h100);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t2_rpc_held", redirect_pc, 32'h100);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("t2_vld_drop", {31'd0, redirect_vld}, 32'd0);

    // return to 0x200
    step(0, 0, 0, 1, 0, 0, 0);
    chk("t4_flush", {31'd0, trap_flush}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t4_rpc", redirect_pc, 32'h200);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("t4_mie", {31'd0, mie}, 32'd1);
    chk("t4_inh", {31'd0, in_handler}, 32'd0);

    // pulse while disabled stays pending, taken at 0x304 after enable
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 1, 32'h300, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    step(0, 1, 32'h304, 0, 0, 0, 0);
    chk("t3_epc", epc, 32'h304);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // mret and pulse together: return first, trap afterwards from pend
    step(1, 1, 32'h500, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1, 0);
    step(1, 1, 32'h600, 1, 0, 0, 0);
    chk("t5_ret_flush", {31'd0, trap_flush}, 32'd1);
    chk("t5_epc_kept", epc, 32'h500);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t5_rpc", redirect_pc, 32'h500);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 32'h604, 0, 0, 0, 0);
    chk("t5_epc", epc, 32'h604);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // reset during the trap redirect
    rst_n = 1'b0;
    #1;
    check_all_zero("t6");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 1, 32'h700 + 32'(i * 4), 0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      bit v, p, mr, cw, cd, rdy;
      v   = ($urandom_range(0, 1) == 1);
      p   = v && ($urandom_range(0, 5) == 0);
      mr  = ($urandom_range(0, 11) == 0);
      cw  = ($urandom_range(0, 7) == 0);
      cd  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      step(p, v, $urandom & 32'hFFFF_FFFC, mr, cw, cd, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
